ddr3_cmd_checker: RTL
=====================

Name: ddr3_cmd_checker

Overview:
- Passive, synthesizable DDR3 command-bus checker on the controller-to-SDRAM command bus, in parallel with the SDRAM model. Consumes CS_N/RAS_N/CAS_N/WE_N/BA/A.
- Decodes each command and tracks per-bank open/closed state and timing.
- Flags protocol/timing violations (tRCD, tRP, tRAS, tRFC, illegal bank state) for bench scoreboards and the $monitor trace.

Parameters:
- NUM_BANKS, 8, number of banks; BA width = $clog2(NUM_BANKS).
- ROW_W, 15, row address width.
- T_RCD, 5, minimum cpu_clk cycles from ACT to RD/WR, same bank.
- T_RP, 5, minimum cycles from PRE to ACT, same bank.
- T_RAS, 15, minimum cycles from ACT to PRE, same bank.
- T_RFC, 44, cycles after REF during which only NOP/DES are legal.

Ports:
- cpu_clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cs_n  in  1  chip select, active low.
- ras_n  in  1  row strobe, active low.
- cas_n  in  1  column strobe, active low.
- we_n  in  1  write enable, active low.
- ba  in  $clog2(NUM_BANKS)  bank address.
- addr  in  ROW_W  address; addr[10] = precharge-all on PRE.
- cmd_code  out  3  registered decode: 0 NOP/DES, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6 MRS, 7 ZQ/other.
- bank_open  out  NUM_BANKS  per-bank open flag.
- open_row  out  ROW_W  row latched for bank ba (combinational read of row table).
- err_valid  out  1  one-cycle pulse per violating command.
- err_code  out  3  1 ACT_OPEN, 2 NOT_OPEN, 3 TRCD, 4 TRP, 5 TRAS, 6 REF_OPEN, 7 TRFC; 0 when none.
- err_bank  out  $clog2(NUM_BANKS)  bank of the violation.
- viol_count  out  16  saturating violation count.
- first_err_code  out  3  sticky first error (optional feature).
- first_err_bank  out  $clog2(NUM_BANKS)  sticky first-error bank (optional feature).

Behaviour:
- Decode {cs_n,ras_n,cas_n,we_n}: 1xxx DES, 0111 NOP, 0011 ACT, 0101 RD, 0100 WR, 0010 PRE, 0001 REF, 0000 MRS, 0110 ZQ.
- Each input sampled once per cpu_clk. cmd_code and err_* are registered, one-cycle latency.
- Reset: all outputs 0, all banks IDLE, counters saturated (no pending timing), rfc_cnt = 0.
- Per-bank FSM:
  - IDLE -ACT-> OPEN: load row, act_cnt <= 1.
  - OPEN -PRE-> IDLE: pre_cnt <= 1.
  - act_cnt and pre_cnt increment each cycle, saturating at max(T_RAS, T_RCD) and T_RP respectively.
  - A command k cycles after ACT sees act_cnt = k.
- Checks, in priority order; one error max per command:
  - TRFC: any non-NOP/DES while rfc_cnt != 0.
  - ACT: bank OPEN -> ACT_OPEN, state and row unchanged. Else pre_cnt < T_RP -> TRP, bank still opens.
  - RD/WR: bank IDLE -> NOT_OPEN. Else act_cnt < T_RCD -> TRCD.
  - PRE single bank: bank OPEN and act_cnt < T_RAS -> TRAS, bank still closes. PRE to an IDLE bank is legal (NOP).
  - PRE-all (addr[10]=1): checks every OPEN bank; err_bank = lowest violating bank. Closes all banks.
  - REF: any bank OPEN -> REF_OPEN, err_bank = lowest open bank. rfc_cnt <= T_RFC regardless, then decrements to 0.
  - MRS/ZQ: with any bank OPEN -> REF_OPEN.
- viol_count increments on each err_valid and saturates at 16'hFFFF.
- rst asserted mid-sequence clears everything on the next edge; the command sampled in that cycle is ignored.

Optional Feature:
- Macro: DDR3_CHK_STICKY_EN.
- Defined: first_err_code/first_err_bank capture the first err_valid after reset and hold until rst.
- Undefined: both ports tied to 0, no extra flops.

Test Plan:
- Reset, ACT bank 2 row 0x1A5, RD bank 2 at +5 cycles -> no error; bank_open = 8'b0000_0100; open_row = 0x1A5 with ba = 2.
- ACT bank 0, RD bank 0 at +3 cycles -> err_valid pulse, err_code = 3, err_bank = 0, viol_count = 1.
- ACT bank 1, PRE bank 1 at +10 cycles -> err_code = 5, bank 1 closed; ACT bank 1 at +2 cycles after PRE -> err_code = 4, viol_count = 2.
- ACT banks 3 and 5, wait 20 cycles, PRE-all, REF at +5, then RD bank 3 at +10 -> PRE/REF clean; RD gives err_code = 7.
- ACT bank 4 twice -> second gives err_code = 1 and row unchanged. With DDR3_CHK_STICKY_EN, a following TRCD error leaves first_err_code = 1, first_err_bank = 4.
- Force 65536+ RD-to-idle errors -> viol_count holds 16'hFFFF. Assert rst for one cycle -> all outputs 0.

Source files
------------

// File: rtl/ddr3_cmd_checker_if.sv
// Command-bus and result bundle for ddr3_cmd_checker: the controller side drives
// the command pins (master), the checker returns its decode and violation reports (slave).
interface ddr3_cmd_checker_if #(
  parameter int NUM_BANKS = 8,
  parameter int ROW_W     = 15
);
  localparam int BA_W = $clog2(NUM_BANKS);

  logic                 cs_n;
  logic                 ras_n;
  logic                 cas_n;
  logic                 we_n;
  logic [BA_W-1:0]      ba;
  logic [ROW_W-1:0]     addr;
  logic [2:0]           cmd_code;
  logic [NUM_BANKS-1:0] bank_open;
  logic [ROW_W-1:0]     open_row;
  logic                 err_valid;
  logic [2:0]           err_code;
  logic [BA_W-1:0]      err_bank;
  logic [15:0]          viol_count;
  logic [2:0]           first_err_code;
  logic [BA_W-1:0]      first_err_bank;

  modport master (
    output cs_n, ras_n, cas_n, we_n, ba, addr,
    input  cmd_code, bank_open, open_row, err_valid, err_code, err_bank,
           viol_count, first_err_code, first_err_bank
  );

  modport slave (
    input  cs_n, ras_n, cas_n, we_n, ba, addr,
    output cmd_code, bank_open, open_row, err_valid, err_code, err_bank,
           viol_count, first_err_code, first_err_bank
  );
endinterface

// File: rtl/ddr3_cmd_checker.sv
// Passive DDR3 command-bus checker: decodes commands, tracks per-bank state and timing,
// reports tRCD/tRP/tRAS/tRFC and bank-state violations. Sticky first error: DDR3_CHK_STICKY_EN.
module ddr3_cmd_checker #(
  parameter int NUM_BANKS = 8,
  parameter int ROW_W     = 15,
  parameter int T_RCD     = 5,
  parameter int T_RP      = 5,
  parameter int T_RAS     = 15,
  parameter int T_RFC     = 44
) (
  input  logic              cpu_clk,
  input  logic              rst,
  ddr3_cmd_checker_if.slave bus
);
  localparam int BA_W    = $clog2(NUM_BANKS);
  localparam int ACT_MAX = (T_RAS > T_RCD) ? T_RAS : T_RCD;
  localparam int ACT_W   = $clog2(ACT_MAX + 1);
  localparam int PRE_W   = $clog2(T_RP + 1);
  localparam int RFC_W   = $clog2(T_RFC + 1);

  localparam logic [ACT_W-1:0] ACT_SAT  = ACT_W'(ACT_MAX);
  localparam logic [ACT_W-1:0] ACT_ONE  = ACT_W'(1);
  localparam logic [ACT_W-1:0] RCD_MIN  = ACT_W'(T_RCD);
  localparam logic [ACT_W-1:0] RAS_MIN  = ACT_W'(T_RAS);
  localparam logic [PRE_W-1:0] PRE_SAT  = PRE_W'(T_RP);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  localparam logic [RFC_W-1:0] RFC_LOAD = RFC_W'(T_RFC);
  localparam logic [RFC_W-1:0] RFC_ONE  = RFC_W'(1);
  localparam logic [RFC_W-1:0] RFC_ZERO = RFC_W'(0);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;
  localparam logic [2:0] CMD_MRS = 3'd6;
  localparam logic [2:0] CMD_ZQ  = 3'd7;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_ACT_OPEN = 3'd1;
  localparam logic [2:0] ERR_NOT_OPEN = 3'd2;
  localparam logic [2:0] ERR_TRCD     = 3'd3;
  localparam logic [2:0] ERR_TRP      = 3'd4;
  localparam logic [2:0] ERR_TRAS     = 3'd5;
  localparam logic [2:0] ERR_REF_OPEN = 3'd6;
  localparam logic [2:0] ERR_TRFC     = 3'd7;

  logic [NUM_BANKS-1:0] r_open;
  logic [ROW_W-1:0]     r_row     [NUM_BANKS];
  logic [ACT_W-1:0]     r_act_cnt [NUM_BANKS];
  logic [PRE_W-1:0]     r_pre_cnt [NUM_BANKS];
  logic [RFC_W-1:0]     r_rfc_cnt;
  logic [2:0]           r_cmd_code;
  logic                 r_err_valid;
  logic [2:0]           r_err_code;
  logic [BA_W-1:0]      r_err_bank;
  logic [15:0]          r_viol_count;

  logic [2:0]           w_cmd;
  logic [2:0]           w_err_code;
  logic [BA_W-1:0]      w_err_bank;
  logic [NUM_BANKS-1:0] w_open_set;
  logic [NUM_BANKS-1:0] w_close;
  logic [NUM_BANKS-1:0] w_tras_hit;
  logic [BA_W-1:0]      w_low_open;
  logic [BA_W-1:0]      w_low_tras;

  // Command decode from the strobe pins; a deselected chip reads as NOP.
  always_comb begin
    w_cmd = CMD_NOP;
    case ({bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n})
      4'b0111: w_cmd = CMD_NOP;
      4'b0011: w_cmd = CMD_ACT;
      4'b0101: w_cmd = CMD_RD;
      4'b0100: w_cmd = CMD_WR;
      4'b0010: w_cmd = CMD_PRE;
      4'b0001: w_cmd = CMD_REF;
      4'b0000: w_cmd = CMD_MRS;
      4'b0110: w_cmd = CMD_ZQ;
      default: w_cmd = CMD_NOP;
    endcase
  end

  // Per-bank open/close strobes and tRAS hazard flags.
  always_comb begin
    w_open_set = {NUM_BANKS{1'b0}};
    w_close    = {NUM_BANKS{1'b0}};
    w_tras_hit = {NUM_BANKS{1'b0}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_open_set[b] = (w_cmd == CMD_ACT) && (bus.ba == BA_W'(b)) && !r_open[b];
      w_close[b]    = (w_cmd == CMD_PRE) && r_open[b] &&
                      (bus.addr[10] || (bus.ba == BA_W'(b)));
      w_tras_hit[b] = r_open[b] && (r_act_cnt[b] < RAS_MIN);
    end
  end

  // Downward scan so the last hit written is the lowest-numbered bank.
  always_comb begin
    w_low_open = {BA_W{1'b0}};
    w_low_tras = {BA_W{1'b0}};
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      w_low_open = r_open[b]     ? BA_W'(b) : w_low_open;
      w_low_tras = w_tras_hit[b] ? BA_W'(b) : w_low_tras;
    end
  end

  // Violation classification; at most one code per command, tRFC lockout first.
  always_comb begin
    w_err_code = ERR_NONE;
    w_err_bank = bus.ba;
    if ((w_cmd != CMD_NOP) && (r_rfc_cnt != RFC_ZERO)) begin
      w_err_code = ERR_TRFC;
    end else begin
      case (w_cmd)
        CMD_ACT: begin
          if (r_open[bus.ba]) begin
            w_err_code = ERR_ACT_OPEN;
          end else if (r_pre_cnt[bus.ba] < PRE_SAT) begin
            w_err_code = ERR_TRP;
          end else begin
            w_err_code = ERR_NONE;
          end
        end
        CMD_RD, CMD_WR: begin
          if (!r_open[bus.ba]) begin
            w_err_code = ERR_NOT_OPEN;
          end else if (r_act_cnt[bus.ba] < RCD_MIN) begin
            w_err_code = ERR_TRCD;
          end else begin
            w_err_code = ERR_NONE;
          end
        end
        CMD_PRE: begin
          if (bus.addr[10]) begin
            if (|w_tras_hit) begin
              w_err_code = ERR_TRAS;
              w_err_bank = w_low_tras;
            end else begin
              w_err_code = ERR_NONE;
            end
          end else if (w_tras_hit[bus.ba]) begin
            w_err_code = ERR_TRAS;
          end else begin
            w_err_code = ERR_NONE;
          end
        end
        CMD_REF, CMD_MRS, CMD_ZQ: begin
          if (|r_open) begin
            w_err_code = ERR_REF_OPEN;
            w_err_bank = w_low_open;
          end else begin
            w_err_code = ERR_NONE;
          end
        end
        default: w_err_code = ERR_NONE;
      endcase
    end
  end

  // Bank state, row table and saturating age counters; reset leaves no timing pending.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_open    <= {NUM_BANKS{1'b0}};
      r_rfc_cnt <= RFC_ZERO;
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_row[b]     <= {ROW_W{1'b0}};
        r_act_cnt[b] <= ACT_SAT;
        r_pre_cnt[b] <= PRE_SAT;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (w_open_set[b]) begin
          r_open[b]    <= 1'b1;
          r_row[b]     <= bus.addr;
          r_act_cnt[b] <= ACT_ONE;
        end else if (r_act_cnt[b] != ACT_SAT) begin
          r_act_cnt[b] <= r_act_cnt[b] + ACT_ONE;
        end
        if (w_close[b]) begin
          r_open[b]    <= 1'b0;
          r_pre_cnt[b] <= PRE_ONE;
        end else if (r_pre_cnt[b] != PRE_SAT) begin
          r_pre_cnt[b] <= r_pre_cnt[b] + PRE_ONE;
        end
      end
      if (w_cmd == CMD_REF) begin
        r_rfc_cnt <= RFC_LOAD;
      end else if (r_rfc_cnt != RFC_ZERO) begin
        r_rfc_cnt <= r_rfc_cnt - RFC_ONE;
      end
    end
  end

  // Registered decode and violation report.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_cmd_code   <= CMD_NOP;
      r_err_valid  <= 1'b0;
      r_err_code   <= ERR_NONE;
      r_err_bank   <= {BA_W{1'b0}};
      r_viol_count <= 16'd0;
    end else begin
      r_cmd_code  <= w_cmd;
      r_err_valid <= (w_err_code != ERR_NONE);
      r_err_code  <= w_err_code;
      r_err_bank  <= (w_err_code != ERR_NONE) ? w_err_bank : {BA_W{1'b0}};
      if ((w_err_code != ERR_NONE) && (r_viol_count != 16'hFFFF)) begin
        r_viol_count <= r_viol_count + 16'd1;
      end
    end
  end

  assign bus.cmd_code   = r_cmd_code;
  assign bus.bank_open  = r_open;
  assign bus.open_row   = r_row[bus.ba];
  assign bus.err_valid  = r_err_valid;
  assign bus.err_code   = r_err_code;
  assign bus.err_bank   = r_err_bank;
  assign bus.viol_count = r_viol_count;

`ifdef DDR3_CHK_STICKY_EN
  logic            r_first_seen;
  logic [2:0]      r_first_code;
  logic [BA_W-1:0] r_first_bank;

  // Capture the first violation after reset and hold it.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      r_first_seen <= 1'b0;
      r_first_code <= ERR_NONE;
      r_first_bank <= {BA_W{1'b0}};
    end else if (!r_first_seen && (w_err_code != ERR_NONE)) begin
      r_first_seen <= 1'b1;
      r_first_code <= w_err_code;
      r_first_bank <= w_err_bank;
    end
  end

  assign bus.first_err_code = r_first_code;
  assign bus.first_err_bank = r_first_bank;
`else
  assign bus.first_err_code = 3'd0;
  assign bus.first_err_bank = {BA_W{1'b0}};
`endif
endmodule
